// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// access type encodings, error codes, FSM state encoding and the
// byte-enable / store-lane replication helpers.
package mem_pkg;

  localparam logic [2:0] TYPE_W  = 3'd0;  // word
  localparam logic [2:0] TYPE_HS = 3'd1;  // half, sign-extended
  localparam logic [2:0] TYPE_BS = 3'd2;  // byte, sign-extended
  localparam logic [2:0] TYPE_HU = 3'd3;  // half, zero-extended
  localparam logic [2:0] TYPE_BU = 3'd4;  // byte, zero-extended

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Encodings 5-7 are not defined and behave as word accesses.
  function automatic size_t size_of(input logic [2:0] t);
    case (t)
      TYPE_HS, TYPE_HU: size_of = SZ_HALF;
      TYPE_BS, TYPE_BU: size_of = SZ_BYTE;
      default:          size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: byte_en = lo[1] ? BE_HALF_HI : BE_HALF_LO;
      SZ_BYTE: byte_en = BE_BYTE0 << lo;
      default: byte_en = BE_WORD;
    endcase
  endfunction

  // Store data is right-aligned; replicate it so every lane carries it and
  // the byte enables alone select where it lands.
  function automatic logic [31:0] lane_rep(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_HALF: lane_rep = {2{d[15:0]}};
      SZ_BYTE: lane_rep = {4{d[7:0]}};
      default: lane_rep = d;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and extension.
// Ports:
//   word   - 32-bit word returned by the data memory
//   lo     - byte offset addr[1:0] of the access
//   typ    - access type (mem_pkg TYPE_*; 5-7 act as word)
//   result - selected lane, sign- or zero-extended to 32 bits
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [2:0]  typ,
  output logic [31:0] result
);

  logic signed [15:0] half_v;
  logic signed [7:0]  byte_v;

  always_comb begin
    half_v = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (typ)
      TYPE_HS: result = {{16{half_v[15]}}, half_v};
      TYPE_HU: result = {16'h0000, half_v};
      TYPE_BS: result = {{24{byte_v[7]}}, byte_v};
      TYPE_BU: result = {24'h000000, byte_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller for the MEM stage.
// Checks alignment and address range, drives a req/ready memory bus with
// byte enables, waits out variable latency (bounded by TIMEOUT) and returns
// extended load data with a one-cycle done pulse.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   req, we, acc_type    - MEM-stage request, store flag, access type
//   addr, wdata          - byte address, right-aligned store data
//   stall                - freeze pipeline while an access is pending
//   done, rdata          - completion pulse, extended load data
//   err, err_code        - error flag and code (valid with done)
//   mem_req, mem_we      - memory bus request / write
//   mem_addr, mem_be     - word address, byte enables
//   mem_wdata            - lane-replicated store data
//   mem_rdata, mem_ready - memory read word, completion strobe
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  acc_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [2:0]        type_q;
  logic [1:0]        lo_q;
  size_t             req_sz;
  logic              misaligned;
  logic              out_of_range;
  logic [32:0]       off;
  logic              tmo_hit;
  logic [31:0]       ext_data;

  load_extend u_load_extend (
    .word   (mem_rdata),
    .lo     (lo_q),
    .typ    (type_q),
    .result (ext_data)
  );

  always_comb begin
    req_sz     = size_of(acc_type);
    misaligned = ((req_sz == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                 ((req_sz == SZ_HALF) && addr[0]);
    // 33-bit offset: a borrow means the address lies below MEM_BASE.
    off          = {1'b0, addr} - {1'b0, MEM_BASE};
    out_of_range = off[32] || (off[31:0] >= MEM_SIZE);
    // The counter starts at 0 on the first WAIT cycle, so TIMEOUT-1 marks
    // the last allowed WAIT cycle.
    tmo_hit      = (cnt == CNT_W'(TIMEOUT - 1));
  end

  assign stall = ((state == ST_IDLE) && req) || (state == ST_WAIT);
  assign done  = (state == ST_RESP) && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = (misaligned || out_of_range) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem_ready || tmo_hit) state_nx = ST_RESP;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus registers, latched request fields, timeout counter and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      cnt       <= '0;
      we_q      <= 1'b0;
      type_q    <= TYPE_W;
      lo_q      <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (misaligned) begin
              err      <= 1'b1;
              err_code <= ERR_MISALIGN;
              rdata    <= '0;
            end else if (out_of_range) begin
              err      <= 1'b1;
              err_code <= ERR_RANGE;
              rdata    <= '0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= byte_en(req_sz, addr[1:0]);
              mem_wdata <= lane_rep(req_sz, wdata);
              we_q      <= we;
              type_q    <= acc_type;
              lo_q      <= addr[1:0];
              cnt       <= '0;
            end
          end
        end
        ST_WAIT: begin
          // Ready wins over a coinciding timeout.
          if (mem_ready) begin
            mem_req  <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            rdata    <= we_q ? 32'h0 : ext_data;
          end else if (tmo_hit) begin
            mem_req  <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            rdata    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scoreboard of expected responses
// (rdata, err, err_code, cycle of done counted from the req cycle).
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [2:0]  acc_type;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic [1:0]  err_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .acc_type(acc_type),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .err(err), .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
    logic [7:0]  cycles;
  } resp_t;

  resp_t       sb[$];
  resp_t       e, o;
  logic        sr, mwe, sf, sd, mrd, tmo;
  logic [3:0]  mbe;
  logic [31:0] maddr, mwd;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Drives one request from the next falling edge and plays the memory:
  // mem_ready is raised on WAIT cycle rdy_on (1-based; 0 = never).
  // Returns at the done cycle with req still held, as the pipeline does.
  task automatic run_access(input logic i_we, input logic [2:0] i_typ,
                            input logic [31:0] i_addr, input logic [31:0] i_wdata,
                            input logic [31:0] i_rword, input int rdy_on);
    int wait_n;
    @(negedge clk);
    req = 1'b1; we = i_we; acc_type = i_typ; addr = i_addr; wdata = i_wdata;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    o = '0; sr = 1'b0; mwe = 1'b0; mbe = 4'h0; maddr = 32'h0; mwd = 32'h0;
    sf = 1'b0; sd = 1'b1; mrd = 1'b1; tmo = 1'b1; wait_n = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (cyc == 1) sf = stall;
      if (done) begin
        o = '{rdata: rdata, err: err, code: err_code, cycles: 8'(cyc)};
        sd = stall; mrd = mem_req; tmo = 1'b0;
        break;
      end
      if (mem_req) begin
        if (!sr) begin
          sr = 1'b1; mwe = mem_we; mbe = mem_be; maddr = mem_addr; mwd = mem_wdata;
        end
        wait_n++;
        mem_ready = (wait_n == rdy_on);
        mem_rdata = i_rword;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    if (tmo) $display("FAIL no_done: done not seen within 40 cycles");
  endtask

  task automatic go_idle();
    @(negedge clk);
    req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; acc_type = TYPE_W; addr = 0; wdata = 0;
    mem_rdata = 0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, err, err_code, done, stall} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h rd=%h err=%b code=%b done=%b stall=%b want all 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, err, err_code, done, stall);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_load_byte_signed();
    sb.push_back('{rdata: 32'hFFFF_FF80, err: 1'b0, code: 2'b00, cycles: 8'd4});
    run_access(1'b0, TYPE_BS, 32'h3, 32'h0, 32'h80FF_0102, 2);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL lb_resp: got %h want %h", o, e); end
    n_cmp++;
    if ({sr, mwe, mbe, maddr} !== {1'b1, 1'b0, 4'b1000, 32'h0}) begin
      n_bad++; $display("FAIL lb_bus: got req=%b we=%b be=%b addr=%h want 1 0 1000 0", sr, mwe, mbe, maddr);
    end
    n_cmp++;
    if ({sf, sd} !== 2'b10) begin
      n_bad++; $display("FAIL lb_stall: got first=%b at_done=%b want 1 0", sf, sd);
    end
    go_idle();
  endtask

  task automatic test_load_half_unsigned();
    sb.push_back('{rdata: 32'h0000_BEEF, err: 1'b0, code: 2'b00, cycles: 8'd3});
    run_access(1'b0, TYPE_HU, 32'h6, 32'h0, 32'hBEEF_1234, 1);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL lhu_resp: got %h want %h", o, e); end
    n_cmp++;
    if ({mbe, maddr} !== {4'b1100, 32'h4}) begin
      n_bad++; $display("FAIL lhu_bus: got be=%b addr=%h want 1100 00000004", mbe, maddr);
    end
    go_idle();
  endtask

  task automatic test_store();
    sb.push_back('{rdata: 32'h0, err: 1'b0, code: 2'b00, cycles: 8'd3});
    run_access(1'b1, TYPE_BU, 32'h1, 32'h0000_00A5, 32'hFFFF_FFFF, 1);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL sb_resp: got %h want %h", o, e); end
    n_cmp++;
    if ({mwe, mbe, mwd} !== {1'b1, 4'b0010, 32'hA5A5_A5A5}) begin
      n_bad++; $display("FAIL sb_bus: got we=%b be=%b wd=%h want 1 0010 a5a5a5a5", mwe, mbe, mwd);
    end
    go_idle();
    sb.push_back('{rdata: 32'h0, err: 1'b0, code: 2'b00, cycles: 8'd3});
    run_access(1'b1, TYPE_HS, 32'h2, 32'h1234_ABCD, 32'h0, 1);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL sh_resp: got %h want %h", o, e); end
    n_cmp++;
    if ({mwe, mbe, mwd} !== {1'b1, 4'b1100, 32'hABCD_ABCD}) begin
      n_bad++; $display("FAIL sh_bus: got we=%b be=%b wd=%h want 1 1100 abcdabcd", mwe, mbe, mwd);
    end
    go_idle();
  endtask

  task automatic test_errors();
    sb.push_back('{rdata: 32'h0, err: 1'b1, code: ERR_MISALIGN, cycles: 8'd2});
    run_access(1'b0, TYPE_W, 32'h2, 32'h0, 32'h0, 1);
    e = sb.pop_front();
    n_cmp++;
    if ({o, sr} !== {e, 1'b0}) begin n_bad++; $display("FAIL misalign_w: got %h req=%b want %h req=0", o, sr, e); end
    go_idle();
    sb.push_back('{rdata: 32'h0, err: 1'b1, code: ERR_MISALIGN, cycles: 8'd2});
    run_access(1'b0, TYPE_HS, 32'h1, 32'h0, 32'h0, 1);
    e = sb.pop_front();
    n_cmp++;
    if ({o, sr} !== {e, 1'b0}) begin n_bad++; $display("FAIL misalign_h: got %h req=%b want %h req=0", o, sr, e); end
    go_idle();
    sb.push_back('{rdata: 32'h0, err: 1'b1, code: ERR_RANGE, cycles: 8'd2});
    run_access(1'b0, TYPE_W, 32'h3000, 32'h0, 32'h0, 1);
    e = sb.pop_front();
    n_cmp++;
    if ({o, sr} !== {e, 1'b0}) begin n_bad++; $display("FAIL range: got %h req=%b want %h req=0", o, sr, e); end
    go_idle();
    // Last legal half-word of the window.
    sb.push_back('{rdata: 32'hFFFF_8001, err: 1'b0, code: ERR_NONE, cycles: 8'd3});
    run_access(1'b0, TYPE_HS, 32'h2FFE, 32'h0, 32'h8001_0000, 1);
    e = sb.pop_front();
    n_cmp++;
    if ({o, maddr} !== {e, 32'h2FFC}) begin n_bad++; $display("FAIL range_edge: got %h addr=%h want %h addr=00002ffc", o, maddr, e); end
    go_idle();
    // Undefined type encoding behaves as a word.
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, code: ERR_NONE, cycles: 8'd3});
    run_access(1'b0, 3'd7, 32'h10, 32'h0, 32'hCAFE_F00D, 1);
    e = sb.pop_front();
    n_cmp++;
    if ({o, mbe} !== {e, 4'b1111}) begin n_bad++; $display("FAIL type7: got %h be=%b want %h be=1111", o, mbe, e); end
    go_idle();
  endtask

  task automatic test_timeout();
    sb.push_back('{rdata: 32'h0, err: 1'b1, code: ERR_TIMEOUT, cycles: 8'd18});
    run_access(1'b0, TYPE_W, 32'h20, 32'h0, 32'h0, 0);
    e = sb.pop_front();
    n_cmp++;
    if ({o, sr, mrd} !== {e, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL timeout: got %h req=%b req_at_done=%b want %h 1 0", o, sr, mrd, e);
    end
    go_idle();
    sb.push_back('{rdata: 32'h1122_3344, err: 1'b0, code: ERR_NONE, cycles: 8'd18});
    run_access(1'b0, TYPE_W, 32'h20, 32'h0, 32'h1122_3344, 16);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL ready_at_limit: got %h want %h", o, e); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    sb.push_back('{rdata: 32'hFFFF_FFFE, err: 1'b0, code: ERR_NONE, cycles: 8'd3});
    sb.push_back('{rdata: 32'h0000_00AB, err: 1'b0, code: ERR_NONE, cycles: 8'd3});
    sb.push_back('{rdata: 32'h0, err: 1'b0, code: ERR_NONE, cycles: 8'd3});
    run_access(1'b0, TYPE_HS, 32'h0, 32'h0, 32'h0000_FFFE, 1);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL b2b_0: got %h want %h", o, e); end
    run_access(1'b0, TYPE_BU, 32'h2, 32'h0, 32'h00AB_0000, 1);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL b2b_1: got %h want %h", o, e); end
    run_access(1'b1, TYPE_W, 32'h8, 32'hDEAD_BEEF, 32'h0, 1);
    e = sb.pop_front();
    n_cmp++;
    if ({o, mbe, mwd} !== {e, 4'b1111, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL b2b_2: got %h be=%b wd=%h want %h 1111 deadbeef", o, mbe, mwd, e);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    @(negedge clk);
    req = 1'b1; we = 1'b0; acc_type = TYPE_W; addr = 32'h40; mem_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got mem_req=%b want 1", mem_req); end
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_req, stall, done} !== 3'b010) begin
      n_bad++; $display("FAIL rst_wait: got mem_req=%b stall=%b done=%b want 0 1 0", mem_req, stall, done);
    end
    reset = 1'b0; req = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      seen = seen | done | mem_req;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_quiet: got activity=%b want 0", seen); end
    sb.push_back('{rdata: 32'h5566_7788, err: 1'b0, code: ERR_NONE, cycles: 8'd4});
    run_access(1'b0, TYPE_W, 32'h44, 32'h0, 32'h5566_7788, 2);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rst_after: got %h want %h", o, e); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_load_byte_signed();
    test_load_half_unsigned();
    test_store();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle data-memory access controller for the MEM stage.
- Accepts one load/store per instruction and checks alignment and address range.
- Drives a req/ready data-memory bus with byte enables, waits out variable memory latency, and returns sign- or zero-extended load data.
- Stalls the pipeline while an access is outstanding; sits between the MEM-stage register and the data memory.

Parameters:
- MEM_BASE, 32'h0000_0000, lowest legal byte address.
- MEM_SIZE, 32'h0000_3000, legal window size in bytes; legal range is [MEM_BASE, MEM_BASE+MEM_SIZE).
- TIMEOUT, 16, maximum cycles spent in WAIT before the access is aborted; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  MEM-stage access request; held while stall=1.
- we  in  1  1=store, 0=load.
- type  in  3  0=word, 1=half signed, 2=byte signed, 3=half unsigned, 4=byte unsigned; 5-7 treated as word.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- stall  out  1  freeze pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data, valid while done=1.
- err  out  1  access error, valid with done.
- err_code  out  2  01=misaligned, 10=out of range, 11=timeout, 00=none.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address, addr with [1:0] forced to 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.
- mem_ready  in  1  memory completes the request this cycle.

Behaviour:
- States: IDLE, WAIT, RESP. Reset forces IDLE, including mid-operation. All registered outputs reset to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, err, err_code. done=0 during reset.
- stall = (state==IDLE & req) | (state==WAIT). Combinational, so stall rises in the same cycle req arrives.
- IDLE, req=1, checks in priority order:
  - misaligned: word with addr[1:0]!=0, or half with addr[0]=1 -> RESP, err_code=01.
  - out of range -> RESP, err_code=10.
  - Errors never assert mem_req.
  - Otherwise latch we, type, addr[1:0] and mem_* fields, set mem_req=1, go to WAIT.
- Byte enables: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0]. Loads drive the same be.
- mem_wdata: word wdata; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
- WAIT:
  - mem_* held stable until mem_ready.
  - On mem_ready: mem_req drops next edge and state goes to RESP.
  - For loads, rdata is registered as the extension of mem_rdata: select lane by latched addr[1:0]; halves take bits [15:0] or [31:16]; sign-extend types 1 and 2, zero-extend types 3 and 4. Stores set rdata=0.
- Timeout: a cycle counter clears on WAIT entry and increments each WAIT cycle without ready. Reaching TIMEOUT with no ready -> mem_req=0, RESP with err_code=11. If mem_ready and the limit coincide, ready wins.
- RESP:
  - done=1 for exactly one cycle; err=(err_code!=0); stall=0. The pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally, so req still high in RESP never re-issues.
  - err, err_code and rdata hold until the next RESP.
- Latency: minimum 3 cycles from req to done (IDLE, WAIT with ready, RESP); error paths take 2.
- Back-to-back: a new req sampled in the IDLE cycle after RESP is accepted normally.

Decomposition:
- Shared package mem_pkg holds: type encodings (TYPE_W, TYPE_HS, TYPE_BS, TYPE_HU, TYPE_BU), err codes, state encoding, and be/replication helper constants.
- One natural sub-module, load_extend: combinational lane-select plus extension (word, addr[1:0], type -> 32-bit result). The FSM, counter and bus registers stay in mem_access_ctrl.

Test Plan:
- Byte-signed load, addr=0x0000_0003, mem_rdata=0x80FF_0102, ready after 2 WAIT cycles -> mem_be=1000, mem_addr=0x0, done at cycle 4, rdata=0xFFFF_FF80, err=0.
- Half-unsigned load, addr=0x6, mem_rdata=0xBEEF_1234, immediate ready -> mem_be=1100, rdata=0x0000_BEEF, done at cycle 3.
- Byte store, addr=0x1, wdata=0x0000_00A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, done with rdata=0.
- Word load at addr=0x2 -> no mem_req, done at cycle 2, err=1, err_code=01. Word load at addr=0x3000 -> err_code=10.
- mem_ready held low -> mem_req drops after 16 WAIT cycles, done with err_code=11. A second run with ready arriving on the 16th WAIT cycle -> normal completion, err=0.
- Reset asserted while in WAIT -> next cycle state IDLE, mem_req=0, stall=req, no done pulse. A following access completes normally.
